// File: rtl/controle_multiciclo_if.sv
`default_nettype none
// ============================================================================
// Module   : controle_multiciclo_if
// Purpose  : Interface bundling the multicycle controller's datapath bus.
// Revision : 1.0 - initial release
// ============================================================================
interface controle_multiciclo_if #(
    parameter int PC_W = 6
);
    logic            start;
    logic            modo;
    logic            parar;
    logic [15:0]     instrucao;
    logic [PC_W-1:0] pc_atual;

    logic            pc_inc;
    logic [2:0]      br_sel_e_sa;
    logic [2:0]      br_sel_sb;
    logic            br_hab_escrita;
    logic [1:0]      ex_controle;
    logic [10:0]     ex_constante;
    logic            mux_ula_sel;
    logic [7:0]      ula_op;
    logic [4:0]      flags_controle;
    logic            flags_we;
    logic            ocupado;
    logic            fim;
    logic            ilegal;
    logic [15:0]     cont_instr;

    modport master (
        output start, modo, parar, instrucao, pc_atual,
        input  pc_inc, br_sel_e_sa, br_sel_sb, br_hab_escrita, ex_controle,
               ex_constante, mux_ula_sel, ula_op, flags_controle, flags_we,
               ocupado, fim, ilegal, cont_instr
    );

    modport slave (
        input  start, modo, parar, instrucao, pc_atual,
        output pc_inc, br_sel_e_sa, br_sel_sb, br_hab_escrita, ex_controle,
               ex_constante, mux_ula_sel, ula_op, flags_controle, flags_we,
               ocupado, fim, ilegal, cont_instr
    );
endinterface
`default_nettype wire

// File: rtl/controle_multiciclo.sv
`default_nettype none
// ============================================================================
// Module   : controle_multiciclo
// Purpose  : Multicycle control unit (FETCH/DECODE/EXEC/WRITE) with registered
//            datapath controls, single-step and continuous-run modes.
// Revision : 1.0 - initial release
// ============================================================================
module controle_multiciclo #(
    parameter int              PC_W     = 6,
    parameter logic [PC_W-1:0] END_PROG = 6'd63
) (
    input  logic                 clock,
    input  logic                 reset,
    controle_multiciclo_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WRITE  = 3'd4
    } state_t;

    localparam logic [1:0] c_FMT_ILL  = 2'b00;
    localparam logic [1:0] c_FMT_ALU  = 2'b10;
    localparam logic [1:0] c_FMT_IMM1 = 2'b01;
    localparam logic [1:0] c_FMT_IMM2 = 2'b11;
    localparam logic [4:0] c_FLAGS_NONE = 5'b11111;

    state_t          r_state, w_state_nxt;
    logic [15:0]     r_ir, w_ir_nxt;
    logic [PC_W-1:0] r_pc_fetch, w_pc_fetch_nxt;
    logic            r_modo, w_modo_nxt;
    logic            r_start_d;
    logic            w_start_edge;
    logic            w_continue;
    logic [1:0]      w_fmt;

    logic            r_pc_inc,         w_pc_inc_nxt;
    logic [2:0]      r_br_sel_e_sa,    w_br_sel_e_sa_nxt;
    logic [2:0]      r_br_sel_sb,      w_br_sel_sb_nxt;
    logic            r_br_hab_escrita, w_br_hab_escrita_nxt;
    logic [1:0]      r_ex_controle,    w_ex_controle_nxt;
    logic [10:0]     r_ex_constante,   w_ex_constante_nxt;
    logic            r_mux_ula_sel,    w_mux_ula_sel_nxt;
    logic [7:0]      r_ula_op,         w_ula_op_nxt;
    logic [4:0]      r_flags_controle, w_flags_controle_nxt;
    logic            r_flags_we,       w_flags_we_nxt;
    logic            r_ocupado;
    logic            r_fim,            w_fim_nxt;
    logic            r_ilegal,         w_ilegal_nxt;
    logic [15:0]     r_cont_instr;

    assign w_start_edge = bus.start & ~r_start_d;
    // Mode is the value latched at launch; parar is checked live at retirement.
    assign w_continue   = r_modo & ~bus.parar & (r_pc_fetch != END_PROG);

    always_comb begin
        w_state_nxt    = r_state;
        w_ir_nxt       = r_ir;
        w_pc_fetch_nxt = r_pc_fetch;
        w_modo_nxt     = r_modo;
        unique case (r_state)
            S_IDLE: begin
                if (w_start_edge) begin
                    w_state_nxt = S_FETCH;
                    w_modo_nxt  = bus.modo;
                end
            end
            S_FETCH: begin
                w_state_nxt    = S_DECODE;
                w_ir_nxt       = bus.instrucao;
                w_pc_fetch_nxt = bus.pc_atual;
            end
            S_DECODE: begin
                if (r_ir[15:14] == c_FMT_ILL)
                    w_state_nxt = w_continue ? S_FETCH : S_IDLE;
                else
                    w_state_nxt = S_EXEC;
            end
            S_EXEC:  w_state_nxt = S_WRITE;
            S_WRITE: w_state_nxt = w_continue ? S_FETCH : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are decoded from the state/IR being entered so they register in step.
    assign w_fmt = w_ir_nxt[15:14];

    always_comb begin
        w_pc_inc_nxt         = 1'b0;
        w_br_sel_e_sa_nxt    = 3'd0;
        w_br_sel_sb_nxt      = 3'd0;
        w_br_hab_escrita_nxt = 1'b0;
        w_ex_controle_nxt    = 2'b00;
        w_ex_constante_nxt   = 11'd0;
        w_mux_ula_sel_nxt    = 1'b0;
        w_ula_op_nxt         = 8'd0;
        w_flags_controle_nxt = 5'd0;
        w_flags_we_nxt       = 1'b0;
        w_fim_nxt            = 1'b0;
        w_ilegal_nxt         = 1'b0;
        unique case (w_state_nxt)
            S_FETCH: w_pc_inc_nxt = 1'b1;
            S_DECODE, S_EXEC, S_WRITE: begin
                if (w_fmt == c_FMT_ALU) begin
                    w_br_sel_e_sa_nxt    = w_ir_nxt[5:3];
                    w_br_sel_sb_nxt      = w_ir_nxt[2:0];
                    w_mux_ula_sel_nxt    = 1'b0;
                    w_flags_controle_nxt = w_ir_nxt[10:6];
                    w_ula_op_nxt         = {w_fmt, w_ir_nxt[10], w_ir_nxt[10:6]};
                end else begin
                    w_br_sel_e_sa_nxt    = w_ir_nxt[13:11];
                    w_br_sel_sb_nxt      = 3'd0;
                    w_mux_ula_sel_nxt    = 1'b1;
                    w_flags_controle_nxt = c_FLAGS_NONE;
                    w_ula_op_nxt         = {w_fmt, w_ir_nxt[10], 5'd0};
                end
                if (w_fmt == c_FMT_IMM1) begin
                    w_ex_controle_nxt  = 2'b00;
                    w_ex_constante_nxt = w_ir_nxt[10:0];
                end else if (w_fmt == c_FMT_IMM2) begin
                    w_ex_controle_nxt  = w_ir_nxt[10] ? 2'b10 : 2'b01;
                    w_ex_constante_nxt = {3'b000, w_ir_nxt[7:0]};
                end
                if (w_state_nxt == S_EXEC)
                    w_flags_we_nxt = 1'b1;
                if (w_state_nxt == S_WRITE) begin
                    w_br_sel_e_sa_nxt    = w_ir_nxt[13:11];
                    w_br_hab_escrita_nxt = 1'b1;
                    w_fim_nxt            = 1'b1;
                end
                if (w_state_nxt == S_DECODE && w_fmt == c_FMT_ILL) begin
                    w_fim_nxt    = 1'b1;
                    w_ilegal_nxt = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state          <= S_IDLE;
            r_ir             <= 16'd0;
            r_pc_fetch       <= '0;
            r_modo           <= 1'b0;
            r_start_d        <= 1'b0;
            r_pc_inc         <= 1'b0;
            r_br_sel_e_sa    <= 3'd0;
            r_br_sel_sb      <= 3'd0;
            r_br_hab_escrita <= 1'b0;
            r_ex_controle    <= 2'b00;
            r_ex_constante   <= 11'd0;
            r_mux_ula_sel    <= 1'b0;
            r_ula_op         <= 8'd0;
            r_flags_controle <= 5'd0;
            r_flags_we       <= 1'b0;
            r_ocupado        <= 1'b0;
            r_fim            <= 1'b0;
            r_ilegal         <= 1'b0;
            r_cont_instr     <= 16'd0;
        end else begin
            r_state          <= w_state_nxt;
            r_ir             <= w_ir_nxt;
            r_pc_fetch       <= w_pc_fetch_nxt;
            r_modo           <= w_modo_nxt;
            r_start_d        <= bus.start;
            r_pc_inc         <= w_pc_inc_nxt;
            r_br_sel_e_sa    <= w_br_sel_e_sa_nxt;
            r_br_sel_sb      <= w_br_sel_sb_nxt;
            r_br_hab_escrita <= w_br_hab_escrita_nxt;
            r_ex_controle    <= w_ex_controle_nxt;
            r_ex_constante   <= w_ex_constante_nxt;
            r_mux_ula_sel    <= w_mux_ula_sel_nxt;
            r_ula_op         <= w_ula_op_nxt;
            r_flags_controle <= w_flags_controle_nxt;
            r_flags_we       <= w_flags_we_nxt;
            r_ocupado        <= (w_state_nxt != S_IDLE);
            r_fim            <= w_fim_nxt;
            r_ilegal         <= w_ilegal_nxt;
            if (w_fim_nxt)
                r_cont_instr <= r_cont_instr + 16'd1;
        end
    end

    assign bus.pc_inc         = r_pc_inc;
    assign bus.br_sel_e_sa    = r_br_sel_e_sa;
    assign bus.br_sel_sb      = r_br_sel_sb;
    assign bus.br_hab_escrita = r_br_hab_escrita;
    assign bus.ex_controle    = r_ex_controle;
    assign bus.ex_constante   = r_ex_constante;
    assign bus.mux_ula_sel    = r_mux_ula_sel;
    assign bus.ula_op         = r_ula_op;
    assign bus.flags_controle = r_flags_controle;
    assign bus.flags_we       = r_flags_we;
    assign bus.ocupado        = r_ocupado;
    assign bus.fim            = r_fim;
    assign bus.ilegal         = r_ilegal;
    assign bus.cont_instr     = r_cont_instr;

endmodule
`default_nettype wire
